// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I/RV32E-subset core with req/ack instruction and data ports.
// Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> WB; illegal conditions park it in HALT.
module mc_core #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] out,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted
);
  localparam int RW = $clog2(REG_COUNT);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;

  logic [31:0] pc, ir, a_q, b_q, imm_q, res_q, npc_q, out_q, daddr_q, dwdata_q;
  logic        dwe_q;
  logic [31:0] rf [REG_COUNT];

  // Instruction fields stay valid from DECODE through WB because ir only changes in FETCH.
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  assign is_r     = (opc == OP_R);
  assign is_i     = (opc == OP_I);
  assign is_ld    = (opc == OP_LD);
  assign is_st    = (opc == OP_ST);
  assign is_br    = (opc == OP_BR);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);

  logic use_rs1, use_rs2, use_rd, legal, bad_reg;
  assign use_rs1 = is_r || is_i || is_ld || is_st || is_br || is_jalr;
  assign use_rs2 = is_r || is_st || is_br;
  assign use_rd  = is_r || is_i || is_ld || is_jal || is_jalr || is_lui || is_auipc;
  assign bad_reg = (use_rs1 && ({27'b0, rs1} >= 32'(REG_COUNT))) ||
                   (use_rs2 && ({27'b0, rs2} >= 32'(REG_COUNT))) ||
                   (use_rd  && ({27'b0, rd}  >= 32'(REG_COUNT)));

  logic [31:0] imm_d;
  always_comb begin
    legal = 1'b0;
    case (opc)
      OP_R:                     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_I:                     legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                                        (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_LD, OP_ST:             legal = (f3 == 3'd2);
      OP_BR:                    legal = (f3 != 3'd2) && (f3 != 3'd3);
      OP_JALR:                  legal = (f3 == 3'd0);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                  legal = 1'b0;
    endcase

    imm_d = {{20{ir[31]}}, ir[31:20]};
    if (is_st)                  imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)             imm_d = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_lui || is_auipc) imm_d = {ir[31:12], 12'b0};
    else if (is_jal)            imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  // Indices beyond REG_COUNT never reach EXEC, so truncating to RW bits is safe.
  logic [31:0] rs1_v, rs2_v;
  assign rs1_v = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
  assign rs2_v = (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];

  logic [31:0] op_b, alu, ex_res, tgt, ex_npc;
  logic [4:0]  sh;
  logic        taken, jump, ex_misalign;
  always_comb begin
    op_b = (is_r || is_br) ? b_q : imm_q;
    sh   = op_b[4:0];
    case (f3)
      3'd0:    alu = (is_r && f7[5]) ? a_q - op_b : a_q + op_b;
      3'd1:    alu = a_q << sh;
      3'd2:    alu = {31'b0, $signed(a_q) < $signed(op_b)};
      3'd3:    alu = {31'b0, a_q < op_b};
      3'd4:    alu = a_q ^ op_b;
      3'd5:    alu = f7[5] ? $unsigned($signed(a_q) >>> sh) : a_q >> sh;
      3'd6:    alu = a_q | op_b;
      default: alu = a_q & op_b;
    endcase

    taken = 1'b0;
    case (f3)
      3'd0:    taken = (a_q == b_q);
      3'd1:    taken = (a_q != b_q);
      3'd4:    taken = ($signed(a_q) <  $signed(b_q));
      3'd5:    taken = ($signed(a_q) >= $signed(b_q));
      3'd6:    taken = (a_q <  b_q);
      3'd7:    taken = (a_q >= b_q);
      default: taken = 1'b0;
    endcase

    tgt    = is_jalr ? ((a_q + imm_q) & ~32'd1) : pc + imm_q;
    jump   = is_jal || is_jalr || (is_br && taken);
    ex_npc = jump ? tgt : pc + 32'd4;

    ex_res = alu;
    if (is_lui)                 ex_res = imm_q;
    else if (is_auipc)          ex_res = pc + imm_q;
    else if (is_jal || is_jalr) ex_res = pc + 32'd4;
    else if (is_ld || is_st)    ex_res = a_q + imm_q;
    else if (is_br)             ex_res = {31'b0, taken};

    ex_misalign = (jump && tgt[1]) || ((is_ld || is_st) && ex_res[1:0] != 2'b00);
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (imem_ack) state_nx = DECODE;
      DECODE:  state_nx = (legal && !bad_reg) ? EXEC : HALT;
      EXEC:    state_nx = ex_misalign ? HALT : (is_ld || is_st) ? MEM : WB;
      MEM:     if (dmem_ack) state_nx = WB;
      WB:      state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      npc_q    <= '0;
      out_q    <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwe_q    <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH:  if (imem_ack) ir <= imem_rdata;
        DECODE: begin
          a_q   <= rs1_v;
          b_q   <= rs2_v;
          imm_q <= imm_d;
        end
        EXEC: begin
          out_q <= ex_res;
          res_q <= ex_res;
          npc_q <= ex_npc;
          // Data-port registers only load for an access that will really be issued.
          if ((is_ld || is_st) && !ex_misalign) begin
            daddr_q  <= ex_res;
            dwe_q    <= is_st;
            dwdata_q <= b_q;
          end
        end
        MEM:    if (dmem_ack && !dwe_q) res_q <= dmem_rdata;
        WB: begin
          pc <= npc_q;
          if (use_rd && rd != 5'd0) rf[rd[RW-1:0]] <= res_q;
        end
        default: ;
      endcase
    end
  end

  // imem_req is gated by rst so it is low during reset even though state sits in FETCH.
  assign imem_req   = rst && (state == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = dmem_req && dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign out        = out_q;
  assign pc_out     = pc;
  assign retire     = (state == WB);
  assign halted     = (state == HALT);
endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: wait-state memory models, retire/fetch/store logs, hand-computed results.
`timescale 1ns/1ps
module tb_mc_core;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, out, pc_out;

  mc_core #(.RESET_PC(RPC), .REG_COUNT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out(out), .pc_out(pc_out), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;

  assign imem_ack   = imem_req && (icnt == iwait);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    icnt <= (!imem_req || imem_ack) ? 0 : icnt + 1;
    dcnt <= (!dmem_req || dmem_ack) ? 0 : dcnt + 1;
    cyc  <= cyc + 1;
  end

  // Logs of fetches, retirements and data accesses, sampled mid-cycle.
  int          rn = 0, fn = 0, dreq = 0, stn = 0, stab_err = 0;
  int          rt_cyc [64];
  logic [31:0] rt_out [64];
  logic [31:0] fa [64];
  logic [31:0] st_addr = '0, st_data = '0, d_addr0 = '0, d_wdata0 = '0;
  logic        d_busy = 1'b0;

  always @(negedge clk) begin
    if (imem_req && imem_ack && fn < 64) begin
      fa[fn] <= imem_addr;
      fn     <= fn + 1;
    end
    if (retire && rn < 64) begin
      rt_cyc[rn] <= cyc;
      rt_out[rn] <= out;
      rn         <= rn + 1;
    end
    if (dmem_req) begin
      dreq <= dreq + 1;
      if (!d_busy) begin
        d_addr0  <= dmem_addr;
        d_wdata0 <= dmem_wdata;
      end else if (dmem_addr !== d_addr0 || dmem_wdata !== d_wdata0) begin
        stab_err <= stab_err + 1;
      end
      d_busy <= !dmem_ack;
      if (dmem_ack && dmem_we) begin
        dmem[dmem_addr[5:2]] <= dmem_wdata;
        stn     <= stn + 1;
        st_addr <= dmem_addr;
        st_data <= dmem_wdata;
      end
    end else begin
      d_busy <= 1'b0;
    end
  end

  int n_cmp = 0, n_err = 0;
  int rn0 = 0, fn0 = 0, dq0 = 0, st0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    rn0 = rn; fn0 = fn; dq0 = dreq; st0 = stn;
    @(negedge clk); #1;
    chk("rel_imem_req", 32'(imem_req), 32'd1);
    chk("rel_imem_addr", imem_addr, RPC);
  endtask

  task automatic wait_ret(input int n);
    for (int k = 0; k < 500 && rn < n; k++) begin
      @(negedge clk); #1;
    end
    chk("retire_budget", rn, n);
  endtask

  task automatic wait_halt();
    for (int k = 0; k < 50 && !halted; k++) begin
      @(negedge clk); #1;
    end
    chk("halted", 32'(halted), 32'd1);
  endtask

  task automatic count_ireq(input string tag, input int ncyc);
    int c;
    c = 0;
    repeat (ncyc) begin
      @(negedge clk); #1;
      if (imem_req) c++;
    end
    chk(tag, c, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Program 1: ALU, memory with waits, branch and jumps, ends on an illegal word.
    clr_imem();
    imem[0]  = i_t(5, 0, 0, 1, 7'h13);          // 100 ADDI x1,x0,5
    imem[1]  = i_t(-3, 0, 0, 2, 7'h13);         // 104 ADDI x2,x0,-3
    imem[2]  = r_t(0, 2, 1, 0, 3);              // 108 ADD  x3,x1,x2
    imem[3]  = r_t(32, 1, 2, 0, 4);             // 10C SUB  x4,x2,x1
    imem[4]  = s_t(8, 3, 0);                    // 110 SW   x3,8(x0)
    imem[5]  = i_t(8, 0, 2, 5, 7'h03);          // 114 LW   x5,8(x0)
    imem[6]  = r_t(0, 4, 5, 0, 6);              // 118 ADD  x6,x5,x4
    imem[7]  = b_t(8, 0, 1, 1);                 // 11C BNE  x1,x0,+8
    imem[9]  = j_t(8, 1);                       // 124 JAL  x1,+8
    imem[11] = r_t(0, 0, 1, 0, 7);              // 12C ADD  x7,x1,x0
    imem[12] = i_t(32'h141, 0, 0, 8, 7'h13);    // 130 ADDI x8,x0,0x141
    imem[13] = i_t(0, 8, 0, 9, 7'h67);          // 134 JALR x9,0(x8)
    imem[16] = j_t(-8, 0);                      // 140 JAL  x0,-8 -> 138 (illegal)

    repeat (2) @(negedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_pc_out", pc_out, RPC);
    chk("rst_out", out, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);

    do_reset();
    wait_ret(rn0 + 4);
    iwait = 3; dwait = 3;
    wait_ret(rn0 + 7);
    iwait = 0; dwait = 0;
    wait_ret(rn0 + 13);
    wait_halt();

    chk("addi_int", rt_cyc[rn0+1] - rt_cyc[rn0], 4);
    chk("sub_int", rt_cyc[rn0+3] - rt_cyc[rn0+2], 4);
    chk("addi_neg_out", rt_out[rn0+1], 32'hFFFF_FFFD);
    chk("add_out", rt_out[rn0+2], 32'd2);
    chk("sub_out", rt_out[rn0+3], 32'hFFFF_FFF8);
    chk("sw_int", rt_cyc[rn0+4] - rt_cyc[rn0+3], 11);
    chk("lw_int", rt_cyc[rn0+5] - rt_cyc[rn0+4], 11);
    chk("addw_int", rt_cyc[rn0+6] - rt_cyc[rn0+5], 7);
    chk("lw_addr_out", rt_out[rn0+5], 32'd8);
    chk("ld_use_out", rt_out[rn0+6], 32'hFFFF_FFFA);
    chk("st_addr", st_addr, 32'd8);
    chk("st_data", st_data, 32'd2);
    chk("st_count", stn - st0, 1);
    chk("dreq_cycles", dreq - dq0, 8);
    chk("bne_out", rt_out[rn0+7], 32'd1);
    chk("bne_fetch", fa[fn0+8], 32'h124);
    chk("jal_link", rt_out[rn0+8], 32'h128);
    chk("jal_fetch", fa[fn0+9], 32'h12C);
    chk("x1_link_out", rt_out[rn0+9], 32'h128);
    chk("jalr_link", rt_out[rn0+11], 32'h138);
    chk("jalr_fetch", fa[fn0+12], 32'h140);
    chk("jal_back_fetch", fa[fn0+13], 32'h138);
    chk("p1_retires", rn - rn0, 13);
    count_ireq("p1_no_fetch", 8);
    chk("p1_fetches", fn - fn0, 14);

    // Program 2: rd=x17 is outside a 16-entry file.
    clr_imem();
    imem[0] = r_t(0, 2, 1, 0, 17);
    do_reset();
    @(negedge clk); #1;
    chk("rc_decode_halted", 32'(halted), 32'd0);
    @(negedge clk); #1;
    chk("rc_halted", 32'(halted), 32'd1);
    count_ireq("rc_no_fetch", 6);
    chk("rc_no_retire", rn - rn0, 0);

    // Program 3: misaligned LW halts in EXEC with no data request.
    clr_imem();
    imem[0] = i_t(6, 0, 2, 5, 7'h03);
    do_reset();
    wait_halt();
    chk("mis_no_dreq", dreq - dq0, 0);
    chk("mis_no_retire", rn - rn0, 0);

    // Program 4: reset while a store is stalled in MEM.
    clr_imem();
    imem[0] = i_t(7, 0, 0, 1, 7'h13);
    imem[1] = s_t(0, 1, 0);
    dwait = 100;
    do_reset();
    wait_ret(rn0 + 1);
    repeat (6) @(negedge clk);
    #1;
    chk("stall_dmem_req", 32'(dmem_req), 32'd1);
    chk("stall_dmem_we", 32'(dmem_we), 32'd1);
    chk("stall_wdata", dmem_wdata, 32'd7);
    chk("stall_addr", dmem_addr, 32'd0);
    rst = 1'b0;
    #1;
    chk("async_dmem_drop", 32'(dmem_req), 32'd0);
    chk("async_imem_low", 32'(imem_req), 32'd0);
    chk("async_out_clr", out, 32'd0);
    dwait = 0;
    clr_imem();
    imem[0] = r_t(0, 0, 1, 0, 6);
    do_reset();
    wait_ret(rn0 + 1);
    chk("post_rst_fetch", fa[fn0], RPC);
    chk("post_rst_x1", rt_out[rn0], 32'd0);
    chk("no_aborted_store", stn - st0, 0);
    chk("stab_err", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mc_core.md
# mc_core

Multi-cycle, parametrised RV32I-subset core that succeeds the single-cycle CPU top. It executes one instruction over several states, fetch, decode, execute, optional memory and writeback. Instruction and data memories are external and attach through req/ack handshakes, so wait-state memories work. `REG_COUNT` selects a 32-register (RV32I) or 16-register (RV32E) file, and illegal or misaligned operations halt the core cleanly.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `REG_COUNT`, default 32: register count, legal values 32 or 16. A register index ≥ `REG_COUNT` is illegal.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output 32: fetch address, equal to the current PC.
- `imem_ack` input 1: fetch complete. `imem_rdata` is valid in the same cycle.
- `imem_rdata` input 32: fetched instruction.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 for store (SW), 0 for load (LW).
- `dmem_addr` output 32: word-aligned byte address.
- `dmem_wdata` output 32: store data (rs2).
- `dmem_ack` input 1: data access complete. `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` input 32: load data.
- `out` output 32: last EXEC ALU result (debug, same role as the existing top's `out`).
- `pc_out` output 32: current PC.
- `retire` output 1: one-cycle pulse when an instruction commits.
- `halted` output 1: core stopped on an illegal condition.

## Operation

- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=PC.
  - On an edge with `imem_req`&`imem_ack`, latch IR and go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - Read rs1/rs2 into operand registers and build the immediate (I/S/B/U/J).
  - Go to HALT if any of these hold: unsupported opcode/funct, or any used register index ≥ `REG_COUNT`. Otherwise go to EXEC.
- **EXEC**
  - Compute the ALU result and the next PC, and update `out`.
  - For LW/SW: if `addr[1:0]`≠0, go to HALT. Otherwise go to MEM.
  - All other instructions go to WB.
- **MEM**
  - `dmem_req`=1. `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable until ack.
  - On `dmem_req`&`dmem_ack`, go to WB. LW latches `dmem_rdata`.
- **WB**
  - Write rd when the instruction writes rd and rd≠0.
  - Update PC to next PC, pulse `retire`, go to FETCH.
- **HALT**: terminal until reset. `halted`=1, no requests, no register or PC changes.
- **Supported instructions**
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LW, SW.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - JAL, JALR (target bit 0 cleared), LUI, AUIPC.
- **Arithmetic rules**
  - All arithmetic is 32-bit modulo, with wrap-around and no overflow flag.
  - Shift amount is `[4:0]`.
  - JAL/JALR write PC+4.
  - Branch/jump targets are PC-relative, computed in EXEC from the PC of the instruction.
  - A misaligned jump target (bit 1 set) goes to HALT in EXEC without writing rd.
- x0 always reads 0, and writes to it are discarded.

## Timing

- **Reset values while `rst`=0**
  - State FETCH, PC=`RESET_PC`, all registers 0.
  - `out`=0, `retire`=0, `halted`=0, `imem_req`=0, `dmem_req`=0.
  - `imem_addr`=`RESET_PC`, `pc_out`=`RESET_PC`, `dmem_*` outputs 0.
- `imem_req` rises in the first cycle after `rst` deasserts.
- **Latency with zero-wait memories** (ack high in the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW/SW: 5 cycles.
  - Each ack wait cycle adds exactly 1 cycle.
- **Handshake rules**
  - A request, once asserted, stays high with stable address and data until ack.
  - Ack while req=0 is ignored.
  - Ack is sampled only in FETCH (imem) or MEM (dmem).
- `retire` is high exactly in the WB cycle. The rd write and PC update take effect at the end of that cycle.
- Reset mid-transaction drops `imem_req`/`dmem_req` immediately (asynchronously). An ack arriving during or after reset for the old request has no effect.
- A store never writes memory after a halt. HALT entered in DECODE or EXEC issues no `dmem_req`.

## Test plan

- **Reset and first fetch:** `RESET_PC`=0x100, release `rst` → `imem_req`=1 and `imem_addr`=0x100 in the next cycle. All outputs hold their reset values before release.
- **ALU sequence, zero wait:** ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 → x3=2, x4=0xFFFF_FFF8, `out`=0xFFFF_FFF8. `retire` pulses every 4 cycles.
- **Memory with waits:** SW x3,8(x0) then LW x5,8(x0), both memories acking after 3 wait cycles → x5=2. LW takes 5+3+3=11 cycles. Address and data stay stable throughout the wait.
- **Branch/jump:** BNE x1,x0,+8 at PC 0x10 → next fetch at 0x18. JAL x1,-16 at 0x18 → x1=0x1C, next fetch at 0x08. JALR to an odd target has bit 0 cleared.
- **Illegal/halt:** with `REG_COUNT`=16, ADD x17,… → `halted`=1 after DECODE, no further `imem_req`. LW at address 0x6 → halt with no `dmem_req`.
- **Reset mid-MEM:** assert `rst` while `dmem_req`=1 with ack held low → `dmem_req` drops asynchronously. After release the core fetches from `RESET_PC` and all registers read 0.
